// File: rtl/conv_pkg.sv
// Shared constants, coefficient tables and the clamp helper used by the
// 3x3 RGB565 convolution stage.
package conv_pkg;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int R_LSB = 11;
  localparam int G_LSB = 5;
  localparam int B_LSB = 0;

  // Wide enough for 9 products of a 6-bit pixel and an 8-bit coefficient.
  localparam int ACC_W = 18;

  typedef logic signed [7:0] coef_t;
  typedef coef_t kernel_t [3][3];

  localparam coef_t C0  = 8'sd0;
  localparam coef_t C1  = 8'sd1;
  localparam coef_t C2  = 8'sd2;
  localparam coef_t C4  = 8'sd4;
  localparam coef_t C5  = 8'sd5;
  localparam coef_t C8  = 8'sd8;
  localparam coef_t CM1 = -8'sd1;

  // Indexed [kernel][row top->bottom][column oldest->newest].
  localparam kernel_t KERNELS [4] = '{
    '{'{C0,  C0,  C0 }, '{C0,  C1, C0 }, '{C0,  C0,  C0 }},
    '{'{C1,  C2,  C1 }, '{C2,  C4, C2 }, '{C1,  C2,  C1 }},
    '{'{C0,  CM1, C0 }, '{CM1, C5, CM1}, '{C0,  CM1, C0 }},
    '{'{CM1, CM1, CM1}, '{CM1, C8, CM1}, '{CM1, CM1, CM1}}
  };

  localparam logic [2:0] SHIFTS [4] = '{3'd0, 3'd4, 3'd0, 3'd0};

  function automatic logic [5:0] clamp(input logic signed [ACC_W-1:0] v,
                                       input logic [5:0]              max_v);
    logic signed [ACC_W-1:0] max_ext;
    max_ext = {{(ACC_W-6){1'b0}}, max_v};
    if (v[ACC_W-1])
      return '0;
    else if (v > max_ext)
      return max_v;
    else
      return v[5:0];
  endfunction

endpackage

// File: rtl/convolution_3x3_channel_mac.sv
// One colour channel of the 3x3 convolution: registered products (S2),
// then sum, arithmetic shift and clamp into the output register (S3).
module channel_mac
  import conv_pkg::*;
#(
  parameter int CH_W = 5
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [2:0][2:0][CH_W-1:0]  win,         // [column][row]
  input  logic [1:0]                 kernel_sel,
  output logic [CH_W-1:0]            result
);

  localparam logic [5:0] CH_MAX = 6'((1 << CH_W) - 1);

  logic signed [ACC_W-1:0] prod_d [3][3];
  logic signed [ACC_W-1:0] prod_q [3][3];
  logic [2:0]              shift_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        prod_d[c][r] = signed'(ACC_W'(win[c][r])) * ACC_W'(KERNELS[kernel_sel][r][c]);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          prod_q[c][r] <= '0;
      shift_q <= '0;
    end else begin
      prod_q  <= prod_d;
      shift_q <= SHIFTS[kernel_sel];
    end
  end

  // NOTE: give every always_comb output a value before any loop or branch so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    acc = '0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        acc = acc + prod_q[c][r];
    shifted = acc >>> shift_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      result <= '0;
    else
      result <= CH_W'(clamp(shifted, CH_MAX));
  end

endmodule

// File: rtl/convolution_3x3.sv
// 3x3 RGB565 convolution stage fed one 3-pixel column per beat from the
// row line buffer; three-cycle pipeline with per-stage valids.
module convolution_3x3
  import conv_pkg::*;
#(
  parameter int HRES        = 1280,
  parameter int VRES        = 720,
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                                    clk_in,
  input  logic                                    rst_n_in,
  input  logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0]  data_in,
  input  logic [$clog2(HRES)-1:0]                 hcount_in,
  input  logic [$clog2(VRES)-1:0]                 vcount_in,
  input  logic                                    data_valid_in,
  input  logic [1:0]                              kernel_sel_in,
  output logic [DATA_WIDTH-1:0]                   pixel_out,
  output logic [$clog2(HRES)-1:0]                 hcount_out,
  output logic [$clog2(VRES)-1:0]                 vcount_out,
  output logic                                    data_valid_out
);

  localparam int HW = $clog2(HRES);
  localparam int VW = $clog2(VRES);

  if (KERNEL_SIZE != 3) begin : g_bad_kernel_size
    $error("convolution_3x3 supports KERNEL_SIZE == 3 only");
  end
  if (DATA_WIDTH != 16) begin : g_bad_data_width
    $error("convolution_3x3 expects RGB565, DATA_WIDTH == 16");
  end

  // Window columns: [0] oldest (left), [2] newest (right).
  logic [2:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] win_q;
  logic [1:0]    active_kernel;
  logic          s1_valid, s2_valid;
  logic [1:0]    s1_kernel;
  logic [HW-1:0] s1_hcount, s2_hcount;
  logic [VW-1:0] s1_vcount, s2_vcount;

  // NOTE: all state uses non-blocking assignment so every register samples
  // the pre-edge value of its neighbours, giving a true shift register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      win_q         <= '0;
      active_kernel <= '0;
      s1_kernel     <= '0;
      s1_valid      <= 1'b0;
      s1_hcount     <= '0;
      s1_vcount     <= '0;
    end else begin
      s1_valid <= data_valid_in && (hcount_in != '0);
      if (data_valid_in) begin
        if (hcount_in == '0) begin
          // Row start replicates the left edge and latches the new kernel.
          win_q         <= {3{data_in}};
          active_kernel <= kernel_sel_in;
          s1_kernel     <= kernel_sel_in;
        end else begin
          win_q[0]  <= win_q[1];
          win_q[1]  <= win_q[2];
          win_q[2]  <= data_in;
          s1_kernel <= active_kernel;
        end
        s1_hcount <= hcount_in - HW'(1);
        s1_vcount <= vcount_in;
      end
    end
  end

  logic [2:0][2:0][R_W-1:0] r_win;
  logic [2:0][2:0][G_W-1:0] g_win;
  logic [2:0][2:0][B_W-1:0] b_win;

  always_comb begin
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++) begin
        r_win[c][r] = win_q[c][r][R_LSB +: R_W];
        g_win[c][r] = win_q[c][r][G_LSB +: G_W];
        b_win[c][r] = win_q[c][r][B_LSB +: B_W];
      end
  end

  logic [R_W-1:0] r_res;
  logic [G_W-1:0] g_res;
  logic [B_W-1:0] b_res;

  channel_mac #(.CH_W(R_W)) u_mac_r (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .win(r_win), .kernel_sel(s1_kernel), .result(r_res)
  );
  channel_mac #(.CH_W(G_W)) u_mac_g (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .win(g_win), .kernel_sel(s1_kernel), .result(g_res)
  );
  channel_mac #(.CH_W(B_W)) u_mac_b (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .win(b_win), .kernel_sel(s1_kernel), .result(b_res)
  );

  // Coordinates and valid ride alongside the MAC pipeline (S2, S3).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s2_valid       <= 1'b0;
      s2_hcount      <= '0;
      s2_vcount      <= '0;
      data_valid_out <= 1'b0;
      hcount_out     <= '0;
      vcount_out     <= '0;
    end else begin
      s2_valid       <= s1_valid;
      s2_hcount      <= s1_hcount;
      s2_vcount      <= s1_vcount;
      data_valid_out <= s2_valid;
      hcount_out     <= s2_hcount;
      vcount_out     <= s2_vcount;
    end
  end

  assign pixel_out = {r_res, g_res, b_res};

endmodule

// File: tb/tb_convolution_3x3.sv
// Randomised bench for convolution_3x3 with a column-history reference model
// and a timestamped expectation queue.
module tb_convolution_3x3;

  localparam int HRES = 1280;
  localparam int VRES = 720;
  localparam int HW   = $clog2(HRES);
  localparam int VW   = $clog2(VRES);

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic [2:0][15:0]  data_in;
  logic [HW-1:0]     hcount_in;
  logic [VW-1:0]     vcount_in;
  logic              data_valid_in;
  logic [1:0]        kernel_sel_in;
  logic [15:0]       pixel_out;
  logic [HW-1:0]     hcount_out;
  logic [VW-1:0]     vcount_out;
  logic              data_valid_out;

  convolution_3x3 dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .data_in(data_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .data_valid_in(data_valid_in),
    .kernel_sel_in(kernel_sel_in), .pixel_out(pixel_out), .hcount_out(hcount_out),
    .vcount_out(vcount_out), .data_valid_out(data_valid_out)
  );

  always #5 clk_in = ~clk_in;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk_in) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Kernels written out row-major (top row first, left to right).
  int ker_tab [4][9] = '{
    '{ 0,  0,  0,   0, 1,  0,   0,  0,  0},
    '{ 1,  2,  1,   2, 4,  2,   1,  2,  1},
    '{ 0, -1,  0,  -1, 5, -1,   0, -1,  0},
    '{-1, -1, -1,  -1, 8, -1,  -1, -1, -1}
  };
  int sh_tab [4] = '{0, 4, 0, 0};

  logic [2:0][15:0] rowbuf [HRES];
  int model_k = 0;

  function automatic logic [15:0] ref_pix(input int k, input int h);
    int res [3];
    for (int ch = 0; ch < 3; ch++) begin
      int acc = 0;
      int mx  = (ch == 1) ? 63 : 31;
      for (int dc = 0; dc < 3; dc++) begin
        int idx = h - 2 + dc;
        if (idx < 0) idx = 0;
        for (int r = 0; r < 3; r++) begin
          logic [15:0] px = rowbuf[idx][r];
          int chv = (ch == 0) ? int'(px[15:11]) : (ch == 1) ? int'(px[10:5]) : int'(px[4:0]);
          acc += ker_tab[k][r*3 + dc] * chv;
        end
      end
      acc = acc >>> sh_tab[k];
      if (acc < 0)  acc = 0;
      if (acc > mx) acc = mx;
      res[ch] = acc;
    end
    return {5'(res[0]), 6'(res[1]), 5'(res[2])};
  endfunction

  typedef struct {
    logic [15:0] pix;
    int          h;
    int          v;
    int          due;
    bit          has_const;
    logic [15:0] cval;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;

  always @(negedge clk_in) begin
    if (rst_n_in && data_valid_out) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(data_valid_out), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("pixel",   32'(pixel_out),  32'(mon_e.pix));
        check("hcount",  32'(hcount_out), 32'(mon_e.h));
        check("vcount",  32'(vcount_out), 32'(mon_e.v));
        check("latency", 32'(cyc),        32'(mon_e.due));
        if (mon_e.has_const)
          check("known_pixel", 32'(pixel_out), 32'(mon_e.cval));
      end
    end
  end

  task automatic beat(input logic [2:0][15:0] col, input int h, input int v, input int k,
                      input bit hc, input logic [15:0] cv);
    @(posedge clk_in); #1;
    data_in       = col;
    hcount_in     = HW'(h);
    vcount_in     = VW'(v);
    kernel_sel_in = 2'(k);
    data_valid_in = 1'b1;
    if (h == 0) model_k = k;
    rowbuf[h] = col;
    if (h > 0)
      sb.push_back('{ref_pix(model_k, h), h - 1, v, cyc + 3, hc, cv});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in); #1;
      data_valid_in = 1'b0;
      data_in       = {16'($urandom), 16'($urandom), 16'($urandom)};
      hcount_in     = HW'($urandom_range(HRES - 1, 0));
    end
  endtask

  logic [15:0] flat_val, flat_exp, spike_val, spike_exp;
  int          spike_col;

  // mode: 0 random, 1 ramp, 2 flat field, 3 single centre spike
  task automatic run_row(input int v, input int len, input int k, input int mode,
                         input int gap_max, input int switch_at, input int k2);
    for (int h = 0; h < len; h++) begin
      logic [2:0][15:0] col;
      bit               hc;
      logic [15:0]      cv;
      hc = 1'b0;
      cv = '0;
      case (mode)
        1: begin
          col = {16'($urandom), 16'(h), 16'($urandom)};
          hc  = 1'b1;
          cv  = 16'(h - 1);
        end
        2: begin
          col = {3{flat_val}};
          hc  = 1'b1;
          cv  = flat_exp;
        end
        3: begin
          col = (h == spike_col) ? {flat_val, spike_val, flat_val} : {3{flat_val}};
          hc  = (h == spike_col + 1);
          cv  = spike_exp;
        end
        default: col = {16'($urandom), 16'($urandom), 16'($urandom)};
      endcase
      beat(col, h, v, (h >= switch_at) ? k2 : k, hc, cv);
      if (gap_max > 0) idle($urandom_range(gap_max, 0));
    end
    idle(1);
  endtask

  localparam int NEVER = 1 << 30;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_in      = 1'b1;
    data_in       = '0;
    hcount_in     = '0;
    vcount_in     = '0;
    data_valid_in = 1'b0;
    kernel_sel_in = '0;
    #2 rst_n_in = 1'b0;
    #1;
    check("rst_valid",  32'(data_valid_out), 32'd0);
    check("rst_pixel",  32'(pixel_out),      32'd0);
    check("rst_hcount", 32'(hcount_out),     32'd0);
    check("rst_vcount", 32'(vcount_out),     32'd0);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;

    // Identity over a full-width ramp row: the last centre emitted is HRES-2.
    run_row(0, HRES, 0, 1, 0, NEVER, 0);

    flat_val = 16'hFFFF; flat_exp = 16'hFFFF;
    run_row(1, 96, 1, 2, 2, NEVER, 0);

    flat_val = 16'hFFFF; spike_val = 16'h0000; spike_col = 40; spike_exp = 16'h0000;
    run_row(2, 64, 2, 3, 1, NEVER, 0);
    flat_val = 16'h0000; spike_val = 16'hFFFF; spike_col = 40; spike_exp = 16'hFFFF;
    run_row(3, 64, 2, 3, 1, NEVER, 0);

    flat_val = 16'h8410; flat_exp = 16'h0000;
    run_row(4, 64, 3, 2, 2, NEVER, 0);

    // Mid-row kernel request is ignored until the next row start.
    run_row(10, 160, 0, 1, 0, 100, 1);
    run_row(11, 60, 1, 0, 0, NEVER, 1);

    for (int i = 0; i < 4; i++)
      run_row(30 + i, $urandom_range(200, 20), $urandom_range(3, 0), 0, 2, NEVER, 0);

    // Asynchronous reset in the middle of a gappy row with beats in flight.
    kernel_sel_in = 2'd3;
    for (int h = 0; h < 30; h++) begin
      beat({16'($urandom), 16'($urandom), 16'($urandom)}, h, 20, 3, 1'b0, '0);
      idle($urandom_range(2, 0));
    end
    beat({16'($urandom), 16'($urandom), 16'($urandom)}, 30, 20, 3, 1'b0, '0);
    #2;
    data_valid_in = 1'b0;
    rst_n_in      = 1'b0;
    #1;
    check("midrst_valid",  32'(data_valid_out), 32'd0);
    check("midrst_pixel",  32'(pixel_out),      32'd0);
    check("midrst_hcount", 32'(hcount_out),     32'd0);
    check("midrst_vcount", 32'(vcount_out),     32'd0);
    sb.delete();
    model_k = 0;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    idle(2);

    run_row(21, 50, 2, 0, 2, NEVER, 0);
    run_row(22, 50, 1, 0, 1, NEVER, 0);

    idle(8);
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
